decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit_pkg.sv | 70 +++++++
 rtl/decode_imm_gen.sv | 34 +++
 rtl/decode_unit.sv | 165 ++++++++++++++++
 tb/tb_decode_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_unit_pkg.sv
// Shared decode definitions: datapath widths, RV32I major opcodes, the
// operation-class encoding presented to the execute stage, the output-register
// FSM states, and small helpers that classify an opcode and report which
// source registers a class actually reads.
package decode_unit_pkg;

    localparam int PC_SIZE  = 32;
    localparam int REG_SIZE = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BXX    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BXX     = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } op_class_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fsm_state_e;

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_BXX:    return CLS_BXX;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_OPIMM:  return CLS_OPIMM;
            OPC_OP:     return CLS_OP;
            OPC_SYSTEM: return CLS_SYSTEM;
            default:    return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic uses_rs1(input op_class_e cls);
        case (cls)
            CLS_JALR, CLS_BXX, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input op_class_e cls);
        case (cls)
            CLS_BXX, CLS_STORE, CLS_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator.
// Ports: instr_hi - instruction bits [31:7] (opcode already classified)
//        op_class - decoded operation class
//        imm      - sign-extended immediate for that class (0 for OP/ILLEGAL)
module decode_imm_gen
    import decode_unit_pkg::*;
(
    input  logic [31:7] instr_hi,
    input  op_class_e   op_class,
    output logic [31:0] imm
);

    // Select the immediate format by class; B and J drop bit 0, U fills low 12 bits with 0.
    always_comb begin
        imm = 32'd0;
        case (op_class)
            CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_SYSTEM:
                imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
            CLS_STORE:
                imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            CLS_BXX:
                imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                       instr_hi[30:25], instr_hi[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm = {instr_hi[31:12], 12'd0};
            CLS_JAL:
                imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                       instr_hi[20], instr_hi[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_unit.sv
// Instruction decode stage with a single output register and a register
// scoreboard. An instruction is captured into the output register when it is
// offered, the register can accept it and none of its sources are pending;
// the execute stage drains it with a valid/ready handshake.
// Ports: clk/rst_ (async active-low), fetch side (decode_start, instruct,
//        pc2decode, decode_ready), flush_flag, regfile read (rs*_addr/rs*_data),
//        writeback retire (wb_valid/wb_rd), execute issue (exu_valid/exu_ready
//        and the registered exu_* payload).
module decode_unit
    import decode_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_,
    input  logic                decode_start,
    input  logic [31:0]         instruct,
    input  logic [PC_SIZE-1:0]  pc2decode,
    output logic                decode_ready,
    input  logic                flush_flag,
    output logic [REG_SIZE-1:0] rs1_addr,
    output logic [REG_SIZE-1:0] rs2_addr,
    input  logic [31:0]         rs1_data,
    input  logic [31:0]         rs2_data,
    input  logic                wb_valid,
    input  logic [REG_SIZE-1:0] wb_rd,
    output logic                exu_valid,
    input  logic                exu_ready,
    output logic [PC_SIZE-1:0]  exu_pc,
    output logic [3:0]          exu_op_class,
    output logic [2:0]          exu_funct3,
    output logic                exu_funct7b5,
    output logic [REG_SIZE-1:0] exu_rd,
    output logic                exu_rd_we,
    output logic [31:0]         exu_imm,
    output logic [31:0]         exu_op1,
    output logic [31:0]         exu_op2,
    output logic                exu_illegal
);

    fsm_state_e        state_r;
    fsm_state_e        state_next_s;
    logic [31:0]       sb_r;
    logic [31:0]       sb_next_s;
    logic [31:0]       sb_set_s;
    logic [31:0]       sb_clr_s;
    op_class_e         cls_s;
    logic [31:0]       imm_s;
    logic [31:0]       op1_s;
    logic [31:0]       op2_s;
    logic              rd_we_s;
    logic [REG_SIZE-1:0] rd_s;
    logic              hazard_s;
    logic              rs1_busy_s;
    logic              rs2_busy_s;
    logic              capture_s;
    logic              issue_s;

    assign rs1_addr = instruct[19:15];
    assign rs2_addr = instruct[24:20];
    assign rd_s     = instruct[11:7];
    assign cls_s    = classify(instruct[6:0]);

    decode_imm_gen u_imm_gen (
        .instr_hi (instruct[31:7]),
        .op_class (cls_s),
        .imm      (imm_s)
    );

    assign exu_valid = (state_r == ST_FULL);

    // A source is busy if already issued and not yet written back, or if it is
    // the destination of the instruction still sitting in the output register.
    assign rs1_busy_s = (rs1_addr != 5'd0) &&
                        (sb_r[rs1_addr] || (exu_valid && exu_rd_we && (exu_rd == rs1_addr)));
    assign rs2_busy_s = (rs2_addr != 5'd0) &&
                        (sb_r[rs2_addr] || (exu_valid && exu_rd_we && (exu_rd == rs2_addr)));
    assign hazard_s   = (uses_rs1(cls_s) && rs1_busy_s) || (uses_rs2(cls_s) && rs2_busy_s);

    assign decode_ready = !hazard_s && (!exu_valid || exu_ready);
    assign capture_s    = decode_start && decode_ready && !flush_flag;
    // An issue counts even under flush: execute has already taken it.
    assign issue_s      = exu_valid && exu_ready;

    // Set wins over clear for the same register; bit 0 never marks busy.
    assign sb_set_s  = (issue_s && exu_rd_we && (exu_rd != 5'd0)) ? (32'd1 << exu_rd) : 32'd0;
    assign sb_clr_s  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign sb_next_s = ((sb_r & ~sb_clr_s) | sb_set_s) & ~32'd1;

    // Destination write enable and operand selection for the captured word.
    always_comb begin
        rd_we_s = 1'b0;
        op1_s   = rs1_data;
        op2_s   = imm_s;
        case (cls_s)
            CLS_BXX, CLS_STORE, CLS_ILLEGAL: rd_we_s = 1'b0;
            default:                         rd_we_s = (rd_s != 5'd0);
        endcase
        case (cls_s)
            CLS_LUI:            op1_s = 32'd0;
            CLS_AUIPC, CLS_JAL: op1_s = 32'(pc2decode);
            default:            op1_s = rs1_data;
        endcase
        case (cls_s)
            CLS_BXX, CLS_STORE, CLS_OP: op2_s = rs2_data;
            default:                    op2_s = imm_s;
        endcase
    end

    // Output-register next state: flush dominates, then capture, then drain.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (flush_flag)     state_next_s = ST_EMPTY;
                else if (capture_s) state_next_s = ST_FULL;
                else                state_next_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (flush_flag)     state_next_s = ST_EMPTY;
                else if (capture_s) state_next_s = ST_FULL;
                else if (issue_s)   state_next_s = ST_EMPTY;
                else                state_next_s = ST_FULL;
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // State and scoreboard registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= ST_EMPTY;
            sb_r    <= 32'd0;
        end else begin
            state_r <= state_next_s;
            sb_r    <= sb_next_s;
        end
    end

    // Payload register: loads only on capture, otherwise holds for a stalled execute.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            exu_pc       <= '0;
            exu_op_class <= 4'd0;
            exu_funct3   <= 3'd0;
            exu_funct7b5 <= 1'b0;
            exu_rd       <= '0;
            exu_rd_we    <= 1'b0;
            exu_imm      <= 32'd0;
            exu_op1      <= 32'd0;
            exu_op2      <= 32'd0;
            exu_illegal  <= 1'b0;
        end else if (capture_s) begin
            exu_pc       <= pc2decode;
            exu_op_class <= cls_s;
            exu_funct3   <= instruct[14:12];
            exu_funct7b5 <= instruct[30];
            exu_rd       <= rd_s;
            exu_rd_we    <= rd_we_s;
            exu_imm      <= imm_s;
            exu_op1      <= op1_s;
            exu_op2      <= op2_s;
            exu_illegal  <= (cls_s == CLS_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit with a fixed register-file model
// (x0 = 0, xN = 0x100 + N).
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        rst_;
    logic        decode_start;
    logic [31:0] instruct;
    logic [31:0] pc2decode;
    logic        decode_ready;
    logic        flush_flag;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        exu_valid, exu_ready;
    logic [31:0] exu_pc;
    logic [3:0]  exu_op_class;
    logic [2:0]  exu_funct3;
    logic        exu_funct7b5;
    logic [4:0]  exu_rd;
    logic        exu_rd_we;
    logic [31:0] exu_imm, exu_op1, exu_op2;
    logic        exu_illegal;

    logic [31:0] regs [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    decode_unit dut (
        .clk(clk), .rst_(rst_), .decode_start(decode_start), .instruct(instruct),
        .pc2decode(pc2decode), .decode_ready(decode_ready), .flush_flag(flush_flag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_pc(exu_pc), .exu_op_class(exu_op_class), .exu_funct3(exu_funct3),
        .exu_funct7b5(exu_funct7b5), .exu_rd(exu_rd), .exu_rd_we(exu_rd_we),
        .exu_imm(exu_imm), .exu_op1(exu_op1), .exu_op2(exu_op2), .exu_illegal(exu_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word from EMPTY with execute stalled; leaves it held in the output register.
    task automatic capture_hold(input logic [31:0] ins, input logic [31:0] pc);
        decode_start = 1'b1; instruct = ins; pc2decode = pc; exu_ready = 1'b0;
        #1;
        check_eq("cap_ready", 32'(decode_ready), 32'd1);
        tick();
        decode_start = 1'b0;
        #1;
        check_eq("cap_valid", 32'(exu_valid), 32'd1);
    endtask

    task automatic release_one();
        exu_ready = 1'b1;
        tick();
        exu_ready = 1'b0;
        #1;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1'b1; wb_rd = r;
        tick();
        wb_valid = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
        rst_ = 1'b0; decode_start = 1'b0; instruct = 32'd0; pc2decode = 32'd0;
        flush_flag = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; exu_ready = 1'b0;
        #2;
        check_eq("rst_valid", 32'(exu_valid), 32'd0);
        check_eq("rst_pc", exu_pc, 32'd0);
        check_eq("rst_imm", exu_imm, 32'd0);
        tick(); tick();
        rst_ = 1'b1;
        tick();

        // addi x5,x0,7 at pc 0x10
        decode_start = 1'b1; instruct = 32'h00700293; pc2decode = 32'h10; exu_ready = 1'b1;
        #1;
        check_eq("addi_ready", 32'(decode_ready), 32'd1);
        tick();
        instruct = 32'h00528333; pc2decode = 32'h14;   // add x6,x5,x5 offered immediately
        #1;
        check_eq("addi_valid", 32'(exu_valid), 32'd1);
        check_eq("addi_class", 32'(exu_op_class), 32'd7);
        check_eq("addi_rd", 32'(exu_rd), 32'd5);
        check_eq("addi_we", 32'(exu_rd_we), 32'd1);
        check_eq("addi_imm", exu_imm, 32'd7);
        check_eq("addi_op2", exu_op2, 32'd7);
        check_eq("addi_op1", exu_op1, 32'd0);
        check_eq("addi_pc", exu_pc, 32'h10);
        check_eq("raw_inflight", 32'(decode_ready), 32'd0);
        tick();
        check_eq("raw_empty", 32'(exu_valid), 32'd0);
        check_eq("raw_sb1", 32'(decode_ready), 32'd0);
        tick();
        check_eq("raw_sb2", 32'(decode_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        check_eq("raw_wb_cycle", 32'(decode_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check_eq("raw_released", 32'(decode_ready), 32'd1);
        tick();
        instruct = 32'h123453B7; pc2decode = 32'h20; exu_ready = 1'b0;   // lui x7,0x12345
        #1;
        check_eq("add_valid", 32'(exu_valid), 32'd1);
        check_eq("add_class", 32'(exu_op_class), 32'd8);
        check_eq("add_rd", 32'(exu_rd), 32'd6);
        check_eq("add_imm", exu_imm, 32'd0);
        check_eq("add_op1", exu_op1, 32'h105);
        check_eq("add_op2", exu_op2, 32'h105);
        check_eq("add_f7b5", 32'(exu_funct7b5), 32'd0);
        check_eq("add_pc", exu_pc, 32'h14);
        check_eq("stall_ready", 32'(decode_ready), 32'd0);

        // Execute stalled for three cycles: payload must hold.
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("hold_valid", 32'(exu_valid), 32'd1);
            check_eq("hold_rd", 32'(exu_rd), 32'd6);
            check_eq("hold_op1", exu_op1, 32'h105);
            check_eq("hold_pc", exu_pc, 32'h14);
            check_eq("hold_ready", 32'(decode_ready), 32'd0);
        end
        exu_ready = 1'b1;
        #1;
        check_eq("handover_ready", 32'(decode_ready), 32'd1);
        tick();
        decode_start = 1'b0;
        #1;
        check_eq("lui_valid", 32'(exu_valid), 32'd1);
        check_eq("lui_class", 32'(exu_op_class), 32'd0);
        check_eq("lui_rd", 32'(exu_rd), 32'd7);
        check_eq("lui_imm", exu_imm, 32'h12345000);
        check_eq("lui_op1", exu_op1, 32'd0);
        check_eq("lui_op2", exu_op2, 32'h12345000);
        check_eq("lui_pc", exu_pc, 32'h20);
        tick();
        check_eq("lui_drained", 32'(exu_valid), 32'd0);
        exu_ready = 1'b0;

        // Flush while EMPTY: offered addi x9 is dropped and not scoreboarded.
        decode_start = 1'b1; flush_flag = 1'b1; instruct = 32'h00100493;
        tick();
        decode_start = 1'b0; flush_flag = 1'b0; instruct = 32'h00048513;   // addi x10,x9,0
        #1;
        check_eq("flush_valid", 32'(exu_valid), 32'd0);
        check_eq("flush_no_sb", 32'(decode_ready), 32'd1);
        instruct = 32'h00030513;   // addi x10,x6,0: x6 still pending
        #1;
        check_eq("flush_sb_kept", 32'(decode_ready), 32'd0);
        retire(5'd6);
        retire(5'd7);

        // Illegal opcode with rd field 6.
        capture_hold(32'h0000037F, 32'h30);
        check_eq("ill_flag", 32'(exu_illegal), 32'd1);
        check_eq("ill_class", 32'(exu_op_class), 32'd10);
        check_eq("ill_we", 32'(exu_rd_we), 32'd0);
        check_eq("ill_imm", exu_imm, 32'd0);
        exu_ready = 1'b1; instruct = 32'h00030513;
        #1;
        check_eq("ill_no_hazard", 32'(decode_ready), 32'd1);
        tick();
        exu_ready = 1'b0;
        #1;
        check_eq("ill_issued", 32'(exu_valid), 32'd0);
        check_eq("ill_no_sb", 32'(decode_ready), 32'd1);

        // beq x0,x0,-4
        capture_hold(32'hFE000EE3, 32'h40);
        check_eq("beq_class", 32'(exu_op_class), 32'd4);
        check_eq("beq_imm", exu_imm, 32'hFFFFFFFC);
        check_eq("beq_op2", exu_op2, 32'd0);
        check_eq("beq_we", 32'(exu_rd_we), 32'd0);
        release_one();
        // sw x5,-8(x2)
        capture_hold(32'hFE512C23, 32'h44);
        check_eq("sw_class", 32'(exu_op_class), 32'd6);
        check_eq("sw_imm", exu_imm, 32'hFFFFFFF8);
        check_eq("sw_op1", exu_op1, 32'h102);
        check_eq("sw_op2", exu_op2, 32'h105);
        check_eq("sw_f3", 32'(exu_funct3), 32'd2);
        check_eq("sw_we", 32'(exu_rd_we), 32'd0);
        release_one();
        // jal x1,8
        capture_hold(32'h008000EF, 32'h48);
        check_eq("jal_class", 32'(exu_op_class), 32'd2);
        check_eq("jal_imm", exu_imm, 32'd8);
        check_eq("jal_op1", exu_op1, 32'h48);
        check_eq("jal_op2", exu_op2, 32'd8);
        check_eq("jal_rd", 32'(exu_rd), 32'd1);
        check_eq("jal_we", 32'(exu_rd_we), 32'd1);

        // Flush coincident with issue: issue still marks x1 busy.
        exu_ready = 1'b1; flush_flag = 1'b1;
        tick();
        exu_ready = 1'b0; flush_flag = 1'b0; instruct = 32'h00008513;   // addi x10,x1,0
        #1;
        check_eq("flushiss_valid", 32'(exu_valid), 32'd0);
        check_eq("flushiss_sb", 32'(decode_ready), 32'd0);
        retire(5'd1);
        check_eq("x1_released", 32'(decode_ready), 32'd1);

        // Reset while FULL with x5 pending both in scoreboard and output register.
        capture_hold(32'h00700293, 32'h50);
        release_one();
        capture_hold(32'h00700293, 32'h54);
        #2;
        rst_ = 1'b0;
        #1;
        check_eq("arst_valid", 32'(exu_valid), 32'd0);
        check_eq("arst_rd", 32'(exu_rd), 32'd0);
        check_eq("arst_we", 32'(exu_rd_we), 32'd0);
        check_eq("arst_imm", exu_imm, 32'd0);
        check_eq("arst_op2", exu_op2, 32'd0);
        check_eq("arst_pc", exu_pc, 32'd0);
        #2;
        rst_ = 1'b1;
        tick();
        decode_start = 1'b1; instruct = 32'h00528333; pc2decode = 32'h58;
        #1;
        check_eq("post_rst_ready", 32'(decode_ready), 32'd1);
        tick();
        decode_start = 1'b0;
        #1;
        check_eq("post_rst_valid", 32'(exu_valid), 32'd1);
        check_eq("post_rst_rd", 32'(exu_rd), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
